uart_tx_arb: RTL and testbench

//  Round-robin arbiter and sequencer sharing one UART transmitter among NREQ byte sources.

---
 rtl/uart_tx_arb.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_arb.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter/sequencer sharing one UART transmitter among NREQ byte
// sources. Grants a requester, captures its byte, strobes the tx write port and
// holds the byte until the transmitter's empty flag returns high, then rotates.
module uart_tx_arb #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned WIDTH_DATA = 8,
    parameter int unsigned TO_CYCLES  = 0
) (
    input  logic                       i_clk,
    input  logic                       i_nrst,
    input  logic [NREQ-1:0]            i_req,
    input  logic [NREQ*WIDTH_DATA-1:0] i_data,
    output logic [NREQ-1:0]            o_ack,
    output logic                       o_we,
    output logic [WIDTH_DATA-1:0]      o_data,
    input  logic                       i_mty,
    output logic [$clog2(NREQ)-1:0]    o_gid,
    output logic                       o_busy,
    output logic                       o_err
);

    localparam int unsigned GidW    = $clog2(NREQ);
    localparam int unsigned IdxW    = GidW + 1;
    localparam int unsigned CntW    = (TO_CYCLES > 0) ? $clog2(TO_CYCLES + 1) : 1;
    localparam int unsigned CntLast = (TO_CYCLES > 0) ? TO_CYCLES - 1 : 0;
    localparam logic [GidW-1:0] GidMax = GidW'(NREQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWaitLo,
        StWaitHi
    } state_e;

    state_e                state_q, state_d;
    logic [GidW-1:0]       ptr_q, ptr_d;
    logic [GidW-1:0]       gid_q, gid_d;
    logic [WIDTH_DATA-1:0] data_q, data_d;
    logic [NREQ-1:0]       ack_q, ack_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic [CntW-1:0]       cnt_q, cnt_d;

    logic                  pick_found;
    logic [GidW-1:0]       pick_idx;
    logic [IdxW-1:0]       cand;
    logic [WIDTH_DATA-1:0] pick_byte;
    logic [GidW-1:0]       gid_inc;
    logic [CntW-1:0]       cnt_inc;
    logic                  wd_expire;

    // Rotating search: first asserted request starting at ptr, wrapping mod NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            cand = {1'b0, ptr_q} + IdxW'(k);
            if (cand >= IdxW'(NREQ)) begin
                cand = cand - IdxW'(NREQ);
            end
            if (!pick_found && i_req[cand[GidW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[GidW-1:0];
            end
        end
    end

    assign pick_byte = i_data[int'(pick_idx) * int'(WIDTH_DATA) +: WIDTH_DATA];

    // Priority after a transfer moves to the source just past the one served.
    assign gid_inc = (gid_q == GidMax) ? '0 : gid_q + GidW'(1);

    // Watchdog counter saturates so a disabled or long wait never wraps.
    assign cnt_inc   = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntW'(1);
    assign wd_expire = (TO_CYCLES != 0) && (cnt_q == CntW'(CntLast));

    // Next-state and registered-output decode; pulses default low every cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        we_d    = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_mty && pick_found) begin
                    state_d = StLoad;
                    gid_d   = pick_idx;
                    data_d  = pick_byte;
                    ack_d   = NREQ'(1) << pick_idx;
                    we_d    = 1'b1;
                end
            end
            StLoad: begin
                state_d = StWaitLo;
                cnt_d   = '0;
            end
            StWaitLo: begin
                // Empty flag dropping means the tx has latched our strobe.
                if (!i_mty) begin
                    state_d = StWaitHi;
                    cnt_d   = '0;
                end else if (wd_expire) begin
                    state_d = StIdle;
                    ptr_d   = gid_inc;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StWaitHi: begin
                // Empty flag rising means the byte moved into the shifter.
                if (i_mty) begin
                    state_d = StIdle;
                    ptr_d   = gid_inc;
                end else if (wd_expire) begin
                    state_d = StIdle;
                    ptr_d   = gid_inc;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset abandons any byte in flight.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gid_q   <= '0;
            data_q  <= '1;
            ack_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            we_q    <= we_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_ack  = ack_q;
    assign o_we   = we_q;
    assign o_data = data_q;
    assign o_gid  = gid_q;
    assign o_busy = busy_q;
    assign o_err  = err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: a transfer-level reference model checked every cycle,
// a small transmitter model driving the empty flag, and directed scenarios
// with literal expectations.
module tb_uart_tx_arb;

    localparam int NREQ = 4;
    localparam int WD   = 8;
    localparam int TO   = 16;

    logic          clk   = 1'b0;
    logic          nrst  = 1'b0;
    logic [3:0]    req   = 4'b0000;
    logic [31:0]   data  = {8'h33, 8'hA5, 8'h22, 8'h11};
    logic          mty   = 1'b1;
    logic [3:0]    ack;
    logic          we;
    logic [7:0]    odata;
    logic [1:0]    gid;
    logic          busy;
    logic          err;

    int checks   = 0;
    int failures = 0;

    // Transmitter model controls.
    int tx_delay    = 3;
    int tx_cnt      = 0;
    bit tx_full     = 1'b0;
    bit tx_stuck    = 1'b0;
    bit tx_hold_low = 1'b0;
    bit tx_flush    = 1'b0;

    int exp_rot[5] = '{0, 1, 2, 3, 0};
    int gseq[5];

    uart_tx_arb #(
        .NREQ      (NREQ),
        .WIDTH_DATA(WD),
        .TO_CYCLES (TO)
    ) dut (
        .i_clk (clk),
        .i_nrst(nrst),
        .i_req (req),
        .i_data(data),
        .o_ack (ack),
        .o_we  (we),
        .o_data(odata),
        .i_mty (mty),
        .o_gid (gid),
        .o_busy(busy),
        .o_err (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Transmitter: empty drops when it sees a write, rises tx_delay cycles later.
    always @(negedge clk) begin
        if (tx_flush) begin
            tx_full = 1'b0;
            tx_cnt  = 0;
        end else if (we) begin
            tx_full = 1'b1;
            tx_cnt  = tx_stuck ? 0 : tx_delay;
        end else if (tx_full && tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) tx_full = 1'b0;
        end
        mty = !(tx_full || tx_hold_low);
    end

    // Reference model: one transfer at a time, described by its age and progress.
    logic [3:0] m_ack;
    logic       m_we, m_busy, m_err;
    logic [7:0] m_data;
    logic [1:0] m_gid, m_ptr;
    bit         m_active, m_took;
    int         m_age, m_wd, m_g;

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_ack    = '0;
            m_we     = 1'b0;
            m_err    = 1'b0;
            m_data   = 8'hFF;
            m_gid    = '0;
            m_ptr    = '0;
            m_active = 1'b0;
            m_busy   = 1'b0;
        end else begin
            m_ack = '0;
            m_we  = 1'b0;
            m_err = 1'b0;
            if (!m_active) begin
                if (mty && req != 4'b0000) begin
                    m_g      = rr_pick(req, int'(m_ptr));
                    m_gid    = 2'(m_g);
                    m_data   = data[m_g*WD +: WD];
                    m_ack    = 4'(1 << m_g);
                    m_we     = 1'b1;
                    m_active = 1'b1;
                    m_took   = 1'b0;
                    m_age    = 0;
                    m_wd     = 0;
                end
            end else begin
                m_age++;
                if (m_age == 1) begin
                    m_wd = 0;
                end else if (m_took ? mty : !mty) begin
                    if (m_took) begin
                        m_active = 1'b0;
                        m_ptr    = 2'((int'(m_gid) + 1) % NREQ);
                    end else begin
                        m_took = 1'b1;
                        m_wd   = 0;
                    end
                end else begin
                    m_wd++;
                    if (m_wd == TO) begin
                        m_err    = 1'b1;
                        m_active = 1'b0;
                        m_ptr    = 2'((int'(m_gid) + 1) % NREQ);
                    end
                end
            end
            m_busy = m_active;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        checks++;
        if ({ack, we, odata, gid, busy, err} !== {m_ack, m_we, m_data, m_gid, m_busy, m_err}) begin
            failures++;
            $display("FAIL model_cmp t=%0t got ack=%b we=%b data=%h gid=%0d busy=%b err=%b want ack=%b we=%b data=%h gid=%0d busy=%b err=%b",
                     $time, ack, we, odata, gid, busy, err,
                     m_ack, m_we, m_data, m_gid, m_busy, m_err);
        end
    end

    task automatic wait_we(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (we) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin : stim
        bit ok;
        bit saw_ack;
        int cnt;

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_data", odata, 8'hFF);
        check("reset_gid", gid, 0);
        check("reset_we_ack_err", {we, ack, err}, 0);
        nrst = 1'b1;

        // 1: single request from source 2.
        @(negedge clk);
        req = 4'b0100;
        wait_we(6, ok);
        check("t1_we_seen", ok, 1);
        check("t1_ack", ack, 4'b0100);
        check("t1_data", odata, 8'hA5);
        check("t1_gid", gid, 2);
        req = 4'b0000;
        @(negedge clk);
        check("t1_we_pulse", {we, ack}, 0);
        check("t1_data_hold", odata, 8'hA5);
        check("t1_busy", busy, 1);
        wait_idle(20, ok);
        check("t1_idle", ok, 1);
        check("t1_data_after", odata, 8'hA5);

        // 2: rotation with all sources requesting, starting from a fresh pointer.
        nrst     = 1'b0;
        tx_flush = 1'b1;
        repeat (2) @(negedge clk);
        tx_flush = 1'b0;
        nrst     = 1'b1;
        req      = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_we(12, ok);
            gseq[i] = ok ? int'(gid) : -1;
        end
        req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_grant%0d", i), gseq[i], exp_rot[i]);
        end
        wait_idle(20, ok);
        check("t2_idle", ok, 1);

        // 3: after serving source 1, source 0 wins over source 1.
        req = 4'b0010;
        wait_we(8, ok);
        check("t3_pre_gid", gid, 1);
        req = 4'b0000;
        wait_idle(20, ok);
        req = 4'b0011;
        wait_we(8, ok);
        check("t3_first", gid, 0);
        req = 4'b0010;
        wait_we(12, ok);
        check("t3_second", gid, 1);
        req = 4'b0000;
        wait_idle(20, ok);
        check("t3_idle", ok, 1);

        // 4: no grant while the transmitter is full.
        tx_hold_low = 1'b1;
        repeat (2) @(negedge clk);
        req = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_no_grant", {we, ack}, 0);
        end
        tx_hold_low = 1'b0;
        wait_we(6, ok);
        check("t4_we_seen", ok, 1);
        check("t4_gid", gid, 0);
        req = 4'b0000;
        wait_idle(20, ok);

        // 5: watchdog with the transmitter stuck not-empty.
        tx_stuck = 1'b1;
        req      = 4'b0010;
        wait_we(6, ok);
        check("t5_gid", gid, 1);
        req     = 4'b0000;
        cnt     = 0;
        saw_ack = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cnt++;
            if (ack != 4'b0000) saw_ack = 1'b1;
            if (err) break;
        end
        check("t5_err_delay", cnt, 18);
        check("t5_no_ack", saw_ack, 0);
        check("t5_busy", busy, 0);
        check("t5_data_kept", odata, 8'h22);
        @(negedge clk);
        check("t5_err_pulse", err, 0);
        tx_stuck = 1'b0;
        tx_flush = 1'b1;
        repeat (2) @(negedge clk);
        tx_flush = 1'b0;

        // 6: reset while waiting for the empty flag to rise.
        req = 4'b0100;
        wait_we(6, ok);
        check("t6_gid", gid, 2);
        req = 4'b0000;
        repeat (2) @(negedge clk);
        check("t6_busy_pre", busy, 1);
        #2 nrst = 1'b0;
        #1;
        check("t6_we_ack", {we, ack}, 0);
        check("t6_data", odata, 8'hFF);
        check("t6_busy", busy, 0);
        tx_flush = 1'b1;
        repeat (2) @(negedge clk);
        tx_flush = 1'b0;
        nrst     = 1'b1;
        req      = 4'b0101;
        wait_we(6, ok);
        check("t6_next_gid", gid, 0);
        check("t6_next_data", odata, 8'h11);
        check("t6_next_ack", ack, 4'b0001);
        req = 4'b0000;
        wait_idle(20, ok);
        check("t6_idle", ok, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL tb_timeout: got running want finished");
        $fatal(1, "bench timeout");
    end

endmodule
